led_serial_encoder: RTL and testbench

- Upstream stage of the top_led chain: turns 24-bit pixel words into the single-wire NRZ bitstream that drives i_serial of the first top_led.
- Pixels arrive on a valid/ready handshake.
- A one-entry holding register lets consecutive pixels go out with no gap on the wire.
- After each frame, ends with a low latch/reset interval so downstream controllers commit their data.

---
 rtl/led_serial_encoder.sv | 130 +++++++++++++
 tb/tb_led_serial_encoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/led_serial_encoder.sv
// Serialises 24-bit pixel words into a single-wire NRZ bitstream for a top_led chain.
// A one-entry holding register keeps pixels gapless, and each frame ends with a low latch interval.
module led_serial_encoder #(
  parameter int T_BIT   = 125,
  parameter int T0H     = 40,
  parameter int T1H     = 80,
  parameter int T_RESET = 5000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [23:0] i_pixel,
  input  logic        i_last,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_serial,
  output logic        o_busy,
  output logic        o_underrun
);

  localparam int CW = (T_BIT > 1) ? $clog2(T_BIT) : 1;
  localparam int LW = $clog2(T_RESET + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(T_BIT - 1);
  localparam logic [CW-1:0] T0H_C    = CW'(T0H);
  localparam logic [CW-1:0] T1H_C    = CW'(T1H);
  localparam logic [LW-1:0] LAT_LAST = LW'(T_RESET - 1);

  if (!(T0H > 0 && T0H < T1H && T1H < T_BIT && T_RESET >= 1)) begin : g_param_check
    $error("led_serial_encoder: timing parameters out of range");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t        state, state_d;
  logic          hold_valid, hold_valid_d;
  logic [23:0]   hold_pixel;
  logic          hold_last;
  logic [23:0]   shifter, shifter_d;
  logic          cur_last, cur_last_d;
  logic [4:0]    bit_cnt, bit_cnt_d;
  logic [CW-1:0] cyc_cnt, cyc_cnt_d;
  logic [LW-1:0] lat_cnt, lat_cnt_d;
  logic          load, accept, underrun_d, serial_d;

  assign accept  = i_valid && !hold_valid;
  assign o_ready = !hold_valid;
  assign o_busy  = (state != IDLE) || hold_valid;

  always_comb begin
    state_d    = state;
    shifter_d  = shifter;
    cur_last_d = cur_last;
    bit_cnt_d  = bit_cnt;
    cyc_cnt_d  = cyc_cnt;
    lat_cnt_d  = lat_cnt;
    load       = 1'b0;
    underrun_d = 1'b0;
    case (state)
      IDLE: if (hold_valid) load = 1'b1;
      SHIFT: begin
        if (cyc_cnt == CYC_LAST) begin
          cyc_cnt_d = '0;
          if (bit_cnt == 5'd0) begin
            if (cur_last) begin
              state_d   = LATCH;
              lat_cnt_d = '0;
            end else if (hold_valid) begin
              load = 1'b1;
            end else begin
              underrun_d = 1'b1;
              state_d    = LATCH;
              lat_cnt_d  = '0;
            end
          end else begin
            bit_cnt_d = bit_cnt - 5'd1;
            shifter_d = {shifter[22:0], 1'b0};
          end
        end else begin
          cyc_cnt_d = cyc_cnt + 1'b1;
        end
      end
      LATCH: begin
        if (lat_cnt == LAT_LAST) state_d = IDLE;
        else                     lat_cnt_d = lat_cnt + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A load from either IDLE or a bit-0 boundary restarts the shifter identically
    if (load) begin
      state_d    = SHIFT;
      shifter_d  = hold_pixel;
      cur_last_d = hold_last;
      bit_cnt_d  = 5'd23;
      cyc_cnt_d  = '0;
    end
    hold_valid_d = load ? 1'b0 : (accept ? 1'b1 : hold_valid);
    // Output is registered, so it is derived from the next-cycle counters
    serial_d = (state_d == SHIFT) && (cyc_cnt_d < (shifter_d[23] ? T1H_C : T0H_C));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      hold_valid <= 1'b0;
      hold_pixel <= '0;
      hold_last  <= 1'b0;
      shifter    <= '0;
      cur_last   <= 1'b0;
      bit_cnt    <= '0;
      cyc_cnt    <= '0;
      lat_cnt    <= '0;
      o_serial   <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      state      <= state_d;
      hold_valid <= hold_valid_d;
      shifter    <= shifter_d;
      cur_last   <= cur_last_d;
      bit_cnt    <= bit_cnt_d;
      cyc_cnt    <= cyc_cnt_d;
      lat_cnt    <= lat_cnt_d;
      o_serial   <= serial_d;
      o_underrun <= underrun_d;
      if (accept) begin
        hold_pixel <= i_pixel;
        hold_last  <= i_last;
      end
    end
  end

endmodule

// File: tb/tb_led_serial_encoder.sv
// Scoreboard bench for led_serial_encoder: stimulus pushes expected pixels, a monitor
// decodes the NRZ waveform back into words, frame ends and underrun pulses.
module tb_led_serial_encoder;
  localparam int T_BIT = 125, T0H = 40, T1H = 80, T_RESET = 5000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [23:0] pixel = '0;
  logic        last = 1'b0, valid = 1'b0;
  logic        ready, serial, busy, underrun;

  int checks = 0, failures = 0;
  int t = 0;

  typedef struct {
    logic [23:0] px;
    bit          ends;
    bit          und;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  led_serial_encoder #(.T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RESET(T_RESET)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pixel(pixel), .i_last(last), .i_valid(valid),
    .o_ready(ready), .o_serial(serial), .o_busy(busy), .o_underrun(underrun)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, t);
    end
  endtask

  // Monitor: decode waveform into words and frame boundaries
  int   prev_s = 0, hi = 0, nbits = 0;
  int   rise_t = 0, frame_end_t = -1000000, und_due = -1;
  bit   und_flag = 0, in_frame = 0, b;
  logic [23:0] word = '0;
  exp_t em;

  always @(negedge clk) begin
    t++;
    if (!rst_n) begin
      prev_s = 0; hi = 0; nbits = 0; in_frame = 0;
      und_due = -1; und_flag = 0; frame_end_t = -1000000;
    end else begin
      check("underrun_pulse", int'(underrun), int'(t == und_due && und_flag));
      if (serial && prev_s == 0) begin
        if (in_frame) check("bit_period", t - rise_t, T_BIT);
        else begin
          check("latch_gap", int'((t - frame_end_t) > T_RESET), 1);
          in_frame = 1;
        end
        rise_t = t;
        hi = 1;
      end else if (serial) begin
        hi++;
      end else if (prev_s != 0) begin
        b = (hi > (T0H + T1H) / 2);
        check("high_width", hi, b ? T1H : T0H);
        word = {word[22:0], b};
        nbits++;
        if (nbits == 24) begin
          nbits = 0;
          if (sb_q.size() == 0) check("pixel_expected", 0, 1);
          else begin
            em = sb_q.pop_front();
            check("pixel", int'(word), int'(em.px));
            if (em.ends) begin
              in_frame    = 0;
              und_due     = rise_t + T_BIT;
              und_flag    = em.und;
              frame_end_t = und_due;
            end
          end
        end
      end
      prev_s = int'(serial);
    end
  end

  task automatic send(input logic [23:0] px, input bit lst, input bit ends, input bit und);
    exp_t e;
    @(negedge clk);
    pixel = px; last = lst; valid = 1'b1;
    for (int i = 0; i < 40000 && !ready; i++) @(negedge clk);
    if (!ready) begin
      check("ready_timeout", 0, 1);
      valid = 1'b0;
      return;
    end
    e.px = px; e.ends = ends; e.und = und;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    valid = 1'b0;
    pixel = 24'($urandom);
    last  = 1'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40000 && (sb_q.size() != 0 || busy); i++) @(negedge clk);
    check("drain", int'(sb_q.size() != 0 || busy), 0);
  endtask

  task automatic backpressure(input int n);
    exp_t e;
    logic [23:0] d;
    int got = 0;
    for (int g = 0; g < 40000 && got < n; g++) begin
      @(negedge clk);
      d = 24'($urandom);
      pixel = d; last = (got == n - 1); valid = 1'b1;
      if (ready) begin
        e.px = d; e.ends = (got == n - 1); e.und = 1'b0;
        sb_q.push_back(e);
        got++;
      end
    end
    check("bp_captures", got, n);
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int high_cnt;
    int n;
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_serial", int'(serial), 0);
    check("rst_ready", int'(ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_underrun", int'(underrun), 0);
    rst_n = 1'b1;
    high_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (serial) high_cnt++;
    end
    check("idle_serial", high_cnt, 0);

    send(24'hA50000, 1, 1, 0);
    @(negedge clk);
    check("lat_hold_serial", int'(serial), 0);
    check("lat_hold_ready", int'(ready), 0);
    @(negedge clk);
    check("lat_first_high", int'(serial), 1);
    check("lat_ready_back", int'(ready), 1);
    repeat (24 * T_BIT + T_RESET - 1) @(negedge clk);
    check("latch_end_busy", int'(busy), 1);
    check("latch_end_serial", int'(serial), 0);
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    wait_done();

    send(24'h123456, 0, 0, 0);
    send(24'hABCDEF, 1, 1, 0);
    wait_done();

    send(24'hFFFFFF, 0, 1, 1);
    wait_done();

    backpressure(3);
    wait_done();

    send(24'($urandom), 0, 0, 0);
    send(24'($urandom), 0, 0, 0);
    send(24'($urandom), 1, 1, 0);
    for (int i = 0; i < 10000 && sb_q.size() > 2; i++) @(negedge clk);
    repeat ($urandom_range(0, 10 * T_BIT)) @(negedge clk);
    for (int i = 0; i < T_BIT && !serial; i++) @(negedge clk);
    check("mid_high", int'(serial), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_serial", int'(serial), 0);
    check("async_rst_ready", int'(ready), 1);
    check("async_rst_busy", int'(busy), 0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(24'($urandom), 1, 1, 0);
    wait_done();

    for (int f = 0; f < 2; f++) begin
      n = $urandom_range(1, 2);
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        send(24'($urandom), k == n - 1, k == n - 1, 0);
      end
      wait_done();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
